// File: rtl/vga_pkg.sv
// Shared types and framebuffer constants for the VGA memory arbiter.
package vga_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } arb_state_t;

    typedef enum logic {
        WR_CPU  = 1'b0,
        WR_DRAW = 1'b1
    } wr_idx_t;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int NUM_WR   = 2;

endpackage

// File: rtl/vga_mem_arbiter_if.sv
// Display/writer/RAM bus of the VGA memory arbiter; ARB_STATS_EN adds the statistics outputs.
interface vga_mem_arbiter_if #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 8
);
    logic              dispReq;
    logic [ADDR_W-1:0] dispAddr;
    logic              dispValid;
    logic [DATA_W-1:0] dispData;
    logic [1:0]        wrReq;
    logic [ADDR_W-1:0] wrAddr0;
    logic [ADDR_W-1:0] wrAddr1;
    logic [DATA_W-1:0] wrData0;
    logic [DATA_W-1:0] wrData1;
    logic [1:0]        wrAck;
    logic [ADDR_W-1:0] memAddr;
    logic              memWe;
    logic [DATA_W-1:0] memWData;
    logic [DATA_W-1:0] memRData;
    logic              starve;
`ifdef ARB_STATS_EN
    logic [15:0]       statWrites;
    logic [15:0]       statMaxWait;

    modport slave (
        input  dispReq, dispAddr, wrReq, wrAddr0, wrAddr1, wrData0, wrData1, memRData,
        output dispValid, dispData, wrAck, memAddr, memWe, memWData, starve,
        output statWrites, statMaxWait
    );
    modport master (
        output dispReq, dispAddr, wrReq, wrAddr0, wrAddr1, wrData0, wrData1, memRData,
        input  dispValid, dispData, wrAck, memAddr, memWe, memWData, starve,
        input  statWrites, statMaxWait
    );
`else
    modport slave (
        input  dispReq, dispAddr, wrReq, wrAddr0, wrAddr1, wrData0, wrData1, memRData,
        output dispValid, dispData, wrAck, memAddr, memWe, memWData, starve
    );
    modport master (
        output dispReq, dispAddr, wrReq, wrAddr0, wrAddr1, wrData0, wrData1, memRData,
        input  dispValid, dispData, wrAck, memAddr, memWe, memWData, starve
    );
`endif
endinterface

// File: rtl/vga_mem_arbiter_rr_arbiter2.sv
// Two-way round-robin writer selection; rr_ptr names the preferred writer.
module rr_arbiter2
    import vga_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    wr_idx_t rr_ptr;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (rr_ptr == WR_DRAW) ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

    // The pointer only moves on an actual grant, so display cycles leave it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      rr_ptr <= WR_CPU;
        else if (gnt[0]) rr_ptr <= WR_DRAW;
        else if (gnt[1]) rr_ptr <= WR_CPU;
    end

endmodule

// File: rtl/vga_mem_arbiter.sv
// Single-port framebuffer arbiter: display reads win, two writers share the rest round-robin.
// Define ARB_STATS_EN to add the statWrites/statMaxWait statistics outputs.
module vga_mem_arbiter
    import vga_pkg::*;
#(
    parameter int ADDR_W       = 19,
    parameter int DATA_W       = 8,
    parameter int STARVE_LIMIT = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    vga_mem_arbiter_if.slave bus
);

    localparam int              CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    arb_state_t                     state, state_nxt;
    logic [NUM_WR-1:0]              gnt;
    logic [NUM_WR-1:0][ADDR_W-1:0]  wr_addr;
    logic [NUM_WR-1:0][DATA_W-1:0]  wr_data;
    logic [NUM_WR-1:0][CNT_W-1:0]   wait_cnt, wait_nxt;
    logic [NUM_WR-1:0]              at_limit;
    logic                           starve_q;
    logic                           wr_sel;

    assign wr_addr = {bus.wrAddr1, bus.wrAddr0};
    assign wr_data = {bus.wrData1, bus.wrData0};

    rr_arbiter2 u_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (!bus.dispReq),
        .req   (bus.wrReq),
        .gnt   (gnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = IDLE;
        if (bus.dispReq)     state_nxt = READ;
        else if (|bus.wrReq) state_nxt = WRITE;
    end

    // Grants are Mealy so every cycle can carry an access; rst_n gating kills a write in flight.
    always_comb begin
        wr_sel        = gnt[WR_DRAW];
        bus.memAddr   = bus.dispAddr;
        bus.memWe     = 1'b0;
        bus.memWData  = wr_data[WR_CPU];
        bus.wrAck     = 2'b00;
        if (rst_n && state_nxt == WRITE) begin
            bus.memWe    = 1'b1;
            bus.memAddr  = wr_addr[wr_sel];
            bus.memWData = wr_data[wr_sel];
            bus.wrAck    = gnt;
        end
        bus.dispValid = (state == READ);
        bus.dispData  = (state == READ) ? bus.memRData : '0;
    end

    always_comb begin
        for (int i = 0; i < NUM_WR; i++) begin
            wait_nxt[i] = wait_cnt[i];
            if (bus.wrAck[i])
                wait_nxt[i] = '0;
            else if (bus.wrReq[i] && wait_cnt[i] != LIMIT)
                wait_nxt[i] = wait_cnt[i] + CNT_W'(1);
            at_limit[i] = (wait_nxt[i] == LIMIT);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            starve_q <= 1'b0;
        end else begin
            wait_cnt <= wait_nxt;
            starve_q <= starve_q | (|at_limit);
        end
    end

    assign bus.starve = starve_q;

`ifdef ARB_STATS_EN
    logic [15:0]      stat_writes;
    logic [15:0]      stat_max_wait;
    logic [CNT_W-1:0] cur_max;

    assign cur_max = (wait_cnt[0] > wait_cnt[1]) ? wait_cnt[0] : wait_cnt[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_writes   <= '0;
            stat_max_wait <= '0;
        end else begin
            if (|bus.wrAck && stat_writes != 16'hFFFF)
                stat_writes <= stat_writes + 16'd1;
            if (32'(cur_max) > 32'(stat_max_wait))
                stat_max_wait <= (32'(cur_max) > 32'hFFFF) ? 16'hFFFF : 16'(cur_max);
        end
    end

    assign bus.statWrites  = stat_writes;
    assign bus.statMaxWait = stat_max_wait;
`endif

endmodule

// File: doc/vga_mem_arbiter.md
VGA_MEM_ARBITER -- requirements
Module: vga_mem_arbiter

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 The block SHALL have these parameters:
- ADDR_W, 19, framebuffer word address width (640x480).
- DATA_W, 8, pixel width (RGB332).
- STARVE_LIMIT, 1024, writer wait cycles before the starve flag sets.
REQ-003 The block SHALL have these ports:
- Clock  in  1  system/pixel clock
- Reset  in  1  asynchronous active-low reset
- dispReq  in  1  display read request, one pixel per cycle
- dispAddr  in  ADDR_W  display read address
- dispValid  out  1  read data valid
- dispData  out  DATA_W  read pixel
- wrReq  in  2  write request per writer (0 = CPU, 1 = draw engine)
- wrAddr0, wrAddr1  in  ADDR_W  write address per writer
- wrData0, wrData1  in  DATA_W  write data per writer
- wrAck  out  2  one-cycle write-accepted pulse per writer
- memAddr  out  ADDR_W  single-port RAM address
- memWe  out  1  RAM write enable
- memWData  out  DATA_W  RAM write data
- memRData  in  DATA_W  RAM read data, 1-cycle latency
- starve  out  1  sticky writer-starvation flag

Function
REQ-004 The block SHALL grant exactly one memory operation per cycle: display read, one write, or none.
REQ-005 dispReq SHALL have absolute priority; when it is high, memAddr=dispAddr and memWe=0 in the same cycle, combinationally.
REQ-006 A read issued in cycle N SHALL give dispValid=1 and dispData=memRData in cycle N+1; back-to-back reads SHALL sustain one per cycle.
REQ-007 In a cycle with dispReq low and at least one wrReq high, the block SHALL grant one writer: memWe=1, memAddr/memWData from that writer, and wrAck[i]=1 in the same cycle.
REQ-008 Writer selection SHALL be round-robin: rrPtr names the preferred writer; after a grant, rrPtr SHALL point to the other writer; if only one writer requests, it SHALL win regardless of rrPtr.
REQ-009 Write handshake:
- The writer holds wrReq, address and data stable until it sees wrAck.
- The writer drops wrReq or presents new data in the cycle after wrAck.
- wrReq high in the cycle after wrAck SHALL be treated as a new request.
REQ-010 The FSM SHALL have states IDLE, READ and WRITE, registered as the last grant type, and SHALL re-evaluate every cycle with no dead cycles between any grant types.
REQ-011 Each writer SHALL have a wait counter that:
- increments while its wrReq is high and it is not granted;
- clears on its wrAck;
- saturates at STARVE_LIMIT.
REQ-012 starve SHALL set when either wait counter reaches STARVE_LIMIT and SHALL stay set until reset.
REQ-013 When neither display nor writers request, the block SHALL drive memWe=0 and memAddr=dispAddr.
REQ-014 A simultaneous dispReq and wrReq SHALL grant the display; the writer stays pending and rrPtr SHALL be unchanged.

Reset
REQ-015 On Reset low, asynchronously, the block SHALL set: state=IDLE, dispValid=0, dispData=0, wrAck=0, memWe=0, starve=0, rrPtr=0, and both wait counters=0.
REQ-016 A reset asserted mid-write SHALL de-assert memWe immediately; no wrAck SHALL be issued for the aborted cycle.

Configuration
REQ-017 With ARB_STATS_EN defined, the block SHALL add outputs statWrites[15:0] (saturating count of wrAck pulses) and statMaxWait[15:0] (largest wait-counter value seen), both reset to 0.
REQ-018 Without ARB_STATS_EN, neither port nor its logic SHALL exist.

Structure
REQ-019 A shared package vga_pkg SHALL hold:
- the FSM state typedef (IDLE/READ/WRITE);
- the writer index enum (WR_CPU=0, WR_DRAW=1);
- the framebuffer constants H_ACTIVE=640 and V_ACTIVE=480.
REQ-020 The round-robin selection and rrPtr SHALL live in the sub-module rr_arbiter2; everything else SHALL stay in vga_mem_arbiter.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- dispReq high 640 cycles with addresses 0..639 -> 640 dispValid pulses, each dispData equal to the RAM contents one cycle later, memWe never 1.
- wrReq=2'b11 with the display idle -> wrAck order 01,10,01,10; RAM holds wrData0/wrData1 at their addresses.
- wrReq[0] held during a 20-cycle dispReq burst -> no wrAck during the burst; wrAck[0] in the first cycle after dispReq falls.
- wrReq[1] held with dispReq high for 1024 cycles -> starve=1 from cycle 1024 and stays 1 after dispReq falls and the write completes.
- Reset pulsed low while memWe=1 -> memWe=0, wrAck=0 and dispValid=0 immediately; after release the pending write is granted with rrPtr=0.
- With ARB_STATS_EN defined, 5 writes where the longest wait is 7 -> statWrites=5 and statMaxWait=7.
